jpeg_stream_out: RTL and testbench

Memory-mapped output port that lets the RISC-V core stream the encoded JPEG bitstream off-chip. It sits on the core's data-memory bus beside the RAM and claims a small register window. It buffers written 32-bit words in a FIFO and serializes them MSB-first as bytes over a valid/ready stream. It optionally performs JPEG 0xFF byte stuffing and flags end-of-image with `out_last`.

---
 rtl/soc_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/jpeg_stream_out.sv | 192 +++++++++++++++++++
 tb/tb_jpeg_stream_out.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared SoC definitions for the JPEG stream output port: register offsets,
// STATUS bit positions, the buffered entry format and serializer states.
// Optional feature macro: JPEG_STREAM_STUFF_EN (adds the STUFF state).
package soc_pkg;

   // Register offsets inside the 16-byte window
   localparam logic [3:0] JSO_DATA   = 4'h0;
   localparam logic [3:0] JSO_RAW    = 4'h4;
   localparam logic [3:0] JSO_LAST   = 4'h8;
   localparam logic [3:0] JSO_STATUS = 4'hC;

   // STATUS register bit positions
   localparam int JSO_ST_FULL    = 0;
   localparam int JSO_ST_IDLE    = 1;
   localparam int JSO_ST_OVF     = 2;
   localparam int JSO_ST_CNT_LSB = 8;
   localparam int JSO_ST_CNT_MSB = 15;

   // One buffered word plus its end-of-image and no-stuffing flags
   typedef struct packed {
      logic        last;
      logic        raw;
      logic [31:0] data;
   } jso_entry_t;

`ifdef JPEG_STREAM_STUFF_EN
   typedef enum logic [1:0] {
      JSO_IDLE,
      JSO_SEND,
      JSO_STUFF
   } jso_state_t;
`else
   typedef enum logic [1:0] {
      JSO_IDLE,
      JSO_SEND
   } jso_state_t;
`endif

   // Picks the byte at position idx of a word, most significant byte first
   function automatic logic [7:0] jsoByteSel(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with exact occupancy count. A push into a full
// FIFO is still accepted when a pop happens on the same edge. DEPTH must be
// a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_pushData,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_popData,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_popData = r_mem[r_rdPtr];
   assign w_doPop   = i_pop && !o_empty;
   assign w_doPush  = i_push && (!o_full || w_doPop);

   // Storage array; contents need no reset because the count gates every read
   always_ff @(posedge clock) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + CW'(1);
         end else if (w_doPop && !w_doPush) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/jpeg_stream_out.sv
// Memory-mapped JPEG bitstream output port. Words written by the core are
// buffered in a FIFO and serialized MSB-first as bytes on a valid/ready
// stream. Optional feature macro: JPEG_STREAM_STUFF_EN inserts a 0x00 after
// every 0xFF byte of non-raw words.
module jpeg_stream_out
   import soc_pkg::*;
#(
   parameter int          WIDTH    = 32,
   parameter int          DEPTH    = 16,
   parameter logic [31:0] BASEADDR = 32'hFFFF_FF00
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] address,
   input  logic [WIDTH-1:0] wdata,
   input  logic             enw,
   output logic             hit,
   output logic [WIDTH-1:0] rdata,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam int CW = $clog2(DEPTH+1);

   logic [3:0]    w_offset;
   logic          w_wrData;
   logic          w_wrRaw;
   logic          w_wrLast;
   logic          w_wrStatus;
   logic          w_push;
   jso_entry_t    w_pushEntry;
   jso_entry_t    w_popEntry;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          w_idle;
   logic          w_handshake;
   logic          w_advance;
   logic          w_wordDone;
   logic [1:0]    w_nextIdx;

   jso_state_t    r_state;
   logic [31:0]   r_wordData;
   logic          r_wordLast;
   logic [1:0]    r_idx;
   logic [7:0]    r_outData;
   logic          r_outValid;
   logic          r_outLast;
   logic          r_overflow;

   assign w_offset    = address[3:0];
   assign hit         = (address[WIDTH-1:4] == BASEADDR[WIDTH-1:4]);
   assign w_wrData    = enw && hit && (w_offset == JSO_DATA);
   assign w_wrRaw     = enw && hit && (w_offset == JSO_RAW);
   assign w_wrLast    = enw && hit && (w_offset == JSO_LAST);
   assign w_wrStatus  = enw && hit && (w_offset == JSO_STATUS);
   assign w_push      = w_wrData || w_wrRaw || w_wrLast;

   assign w_pushEntry.last = w_wrLast;
   assign w_pushEntry.raw  = w_wrRaw || w_wrLast;
   assign w_pushEntry.data = wdata[31:0];

   sync_fifo #(
      .WIDTH ($bits(jso_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_push),
      .i_pushData (w_pushEntry),
      .i_pop      (w_pop),
      .o_popData  (w_popEntry),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   assign w_handshake = r_outValid && out_ready;
   assign w_nextIdx   = r_idx + 2'd1;

`ifdef JPEG_STREAM_STUFF_EN
   logic r_wordRaw;
   logic w_needStuff;

   assign w_needStuff = w_handshake && (r_state == JSO_SEND) && !r_wordRaw && (r_outData == 8'hFF);
   assign w_advance   = w_handshake && !w_needStuff;
`else
   logic w_unusedRaw;

   assign w_unusedRaw = w_popEntry.raw;
   assign w_advance   = w_handshake;
`endif

   assign w_wordDone = w_advance && (r_idx == 2'd3);
   assign w_pop      = !w_empty && ((r_state == JSO_IDLE) || w_wordDone);
   assign w_idle     = w_empty && (r_state == JSO_IDLE);

   // Serializer: loads words from the FIFO and steps through their bytes,
   // chaining straight into the next word so there is no bubble between them
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= JSO_IDLE;
         r_wordData <= '0;
         r_wordLast <= 1'b0;
         r_idx      <= 2'd0;
         r_outData  <= 8'h00;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
      end else if (r_state == JSO_IDLE) begin
         if (!w_empty) begin
            r_state    <= JSO_SEND;
            r_wordData <= w_popEntry.data;
            r_wordLast <= w_popEntry.last;
            r_idx      <= 2'd0;
            r_outData  <= w_popEntry.data[31:24];
            r_outValid <= 1'b1;
            r_outLast  <= 1'b0;
         end
      end
`ifdef JPEG_STREAM_STUFF_EN
      else if (w_needStuff) begin
         r_state   <= JSO_STUFF;
         r_outData <= 8'h00;
         r_outLast <= 1'b0;
      end
`endif
      else if (w_advance) begin
         if (r_idx == 2'd3) begin
            if (!w_empty) begin
               r_state    <= JSO_SEND;
               r_wordData <= w_popEntry.data;
               r_wordLast <= w_popEntry.last;
               r_idx      <= 2'd0;
               r_outData  <= w_popEntry.data[31:24];
               r_outValid <= 1'b1;
               r_outLast  <= 1'b0;
            end else begin
               r_state    <= JSO_IDLE;
               r_idx      <= 2'd0;
               r_outValid <= 1'b0;
               r_outLast  <= 1'b0;
            end
         end else begin
            r_state   <= JSO_SEND;
            r_idx     <= w_nextIdx;
            r_outData <= jsoByteSel(r_wordData, w_nextIdx);
            r_outLast <= r_wordLast && (w_nextIdx == 2'd3);
         end
      end
   end

`ifdef JPEG_STREAM_STUFF_EN
   // Remembers whether the word in the shift register may be stuffed
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wordRaw <= 1'b0;
      end else if (w_pop) begin
         r_wordRaw <= w_popEntry.raw;
      end
   end
`endif

   // Sticky overflow flag: set when a word is dropped, cleared by any STATUS write
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_wrStatus) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   // Read mux: only STATUS is readable, everything else in the window reads 0
   always_comb begin
      rdata = '0;
      if (hit && (w_offset == JSO_STATUS)) begin
         rdata[JSO_ST_FULL]                   = w_full;
         rdata[JSO_ST_IDLE]                   = w_idle;
         rdata[JSO_ST_OVF]                    = r_overflow;
         rdata[JSO_ST_CNT_MSB:JSO_ST_CNT_LSB] = 8'(w_count);
      end
   end

   assign out_data  = r_outData;
   assign out_valid = r_outValid;
   assign out_last  = r_outLast;

endmodule

// File: tb/tb_jpeg_stream_out.sv
// Self-checking bench for jpeg_stream_out. Expected bytes are queued when a
// word is written and compared as the stream hands them off. Follows the
// JPEG_STREAM_STUFF_EN macro the same way the design does.
module tb_jpeg_stream_out;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        enw;
   logic        hit;
   logic [31:0] rdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   int          checks = 0;
   int          errors = 0;
   logic [8:0]  expQ[$];

   jpeg_stream_out #(
      .WIDTH    (32),
      .DEPTH    (16),
      .BASEADDR (BASE)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .address   (address),
      .wdata     (wdata),
      .enw       (enw),
      .hit       (hit),
      .rdata     (rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Single comparison point; every check counts here
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Reference model: the byte sequence a written word should produce
   function automatic void modelWord(input logic [3:0] off, input logic [31:0] data);
      logic       raw;
      logic       last;
      logic [7:0] b;
      raw  = (off != 4'h0);
      last = (off == 4'h8);
      for (int i = 0; i < 4; i++) begin
         b = data[31-8*i -: 8];
         expQ.push_back({last && (i == 3), b});
`ifdef JPEG_STREAM_STUFF_EN
         if (!raw && (b == 8'hFF)) begin
            expQ.push_back({1'b0, 8'h00});
         end
`endif
      end
   endfunction

   // One bus write, driven from a negedge and lasting one clock
   task automatic applyStimulus(input logic [3:0] off, input logic [31:0] data, input bit accepted);
      address = BASE | {28'h0, off};
      wdata   = data;
      enw     = 1'b1;
      if (accepted && (off != 4'hC)) begin
         modelWord(off, data);
      end
      @(negedge clock);
      enw     = 1'b0;
      address = 32'h0;
      wdata   = 32'h0;
   endtask

   task automatic readStatus(output logic [31:0] v);
      address = BASE + 32'hC;
      #1;
      v = rdata;
      address = 32'h0;
   endtask

   // Waits (bounded) until all expected bytes are out and the stream is idle
   task automatic drain(input int maxCycles, input bit randomReady);
      for (int c = 0; c < maxCycles && (expQ.size() != 0 || out_valid); c++) begin
         if (randomReady) out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      out_ready = 1'b1;
      checkOutput("drainQueue", expQ.size(), 0);
      checkOutput("drainIdle", out_valid, 1'b0);
   endtask

   // Stream monitor: compares each accepted byte and checks stall stability
   initial begin
      logic       prevStall;
      logic [9:0] prevOut;
      logic [8:0] exp;
      prevStall = 1'b0;
      prevOut   = '0;
      forever begin
         @(negedge clock);
         #1;
         if (prevStall && !reset) begin
            checkOutput("hold", {out_valid, out_last, out_data}, prevOut);
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("extraByte", out_valid, 1'b0);
            end else begin
               exp = expQ.pop_front();
               checkOutput("byte", out_data, exp[7:0]);
               checkOutput("last", out_last, exp[8]);
            end
         end
         prevStall = out_valid && !out_ready;
         prevOut   = {out_valid, out_last, out_data};
      end
   end

   // Runaway guard
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] st;
      logic [31:0] rnd;
      logic [3:0]  off;
      reset     = 1'b1;
      address   = 32'h0;
      wdata     = 32'h0;
      enw       = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("rstValid", out_valid, 1'b0);
      checkOutput("rstData", out_data, 8'h00);
      checkOutput("rstLast", out_last, 1'b0);
      readStatus(st);
      checkOutput("rstStatus", st, 32'h0000_0002);
      reset = 1'b0;
      @(negedge clock);

      // Address decode
      address = BASE + 32'h4;
      #1 checkOutput("hitInside", hit, 1'b1);
      checkOutput("rdataNonStatus", rdata, 32'h0);
      address = BASE - 32'h4;
      #1 checkOutput("hitOutside", hit, 1'b0);
      address = 32'h0;

      // Basic word, latency and back-to-back bytes
      $display("[TB] basic word");
      applyStimulus(4'h0, 32'h1234_5678, 1'b1);
      checkOutput("latWriteEdge", out_valid, 1'b0);
      @(negedge clock);
      checkOutput("latLoadEdge", out_valid, 1'b1);
      repeat (3) begin
         @(negedge clock);
         checkOutput("noGap1", out_valid, 1'b1);
      end
      @(negedge clock);
      checkOutput("doneValid", out_valid, 1'b0);
      readStatus(st);
      checkOutput("idleStatus", st, 32'h0000_0002);

      // Back-pressure
      $display("[TB] stall");
      out_ready = 1'b0;
      applyStimulus(4'h0, 32'hAABB_CCDD, 1'b1);
      @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stallValid", out_valid, 1'b1);
         checkOutput("stallData", out_data, 8'hAA);
         if (i < 4) @(negedge clock);
      end
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clock);
         checkOutput("noGap2", out_valid, 1'b1);
      end
      @(negedge clock);
      checkOutput("doneValid2", out_valid, 1'b0);

      // Fill, overflow and overflow clear
      $display("[TB] overflow");
      out_ready = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(4'h0, {i[7:0], 8'hA5, ~i[7:0], 8'h3C}, 1'b1);
      end
      readStatus(st);
      checkOutput("fullStatus", st, 32'h0000_1001);
      applyStimulus(4'h0, 32'hDEAD_BEEF, 1'b0);
      readStatus(st);
      checkOutput("ovfStatus", st, 32'h0000_1005);
      applyStimulus(4'hC, 32'h0, 1'b0);
      readStatus(st);
      checkOutput("ovfClear", st, 32'h0000_1001);
      out_ready = 1'b1;
      drain(200, 1'b0);

      // Stuffing, raw markers and end-of-image flag
      $display("[TB] stuffing and last");
      applyStimulus(4'h0, 32'h12FF_3456, 1'b1);
      applyStimulus(4'h4, 32'hFFD8_FFE0, 1'b1);
      applyStimulus(4'h8, 32'h0000_FFD9, 1'b1);
      drain(100, 1'b0);

      // Random words under random back-pressure
      $display("[TB] random traffic");
      for (int w = 0; w < 10; w++) begin
         out_ready = 1'($urandom_range(0, 1));
         off = 4'(4 * $urandom_range(0, 2));
         rnd = $urandom;
         if (w % 2 == 1) rnd[23:16] = 8'hFF;
         applyStimulus(off, rnd, 1'b1);
      end
      drain(800, 1'b1);

      // Reset in the middle of a word
      $display("[TB] reset abort");
      out_ready = 1'b1;
      applyStimulus(4'h0, 32'h1122_3344, 1'b1);
      applyStimulus(4'h0, 32'h5566_7788, 1'b1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("abortValid", out_valid, 1'b0);
      expQ.delete();
      readStatus(st);
      checkOutput("abortStatus", st, 32'h0000_0002);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         checkOutput("postAbortValid", out_valid, 1'b0);
      end
      applyStimulus(4'h8, 32'h0000_FFD9, 1'b1);
      drain(100, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
